// File: rtl/sipo_stream_buffer_pkg.sv
// sipo_stream_buffer_pkg: state encoding for the word packer
package sipo_stream_buffer_pkg;
    typedef enum logic {S_FILL = 1'b0, S_HOLD = 1'b1} state_t;
endpackage

// File: rtl/sipo_stream_buffer.sv
// sipo_stream_buffer: handshaked serial-in/parallel-out word packer with early flush on in_last
module sipo_stream_buffer
    import sipo_stream_buffer_pkg::*;
#(
    parameter int WIDTH        = 64,
    parameter int DEPTH        = 17,
    parameter bit FIRST_AT_MSB = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DEPTH*WIDTH-1:0]     out_data,
    output logic [$clog2(DEPTH+1)-1:0] out_count,
    output logic                       out_last
);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_slot [DEPTH];
    logic [CNT_W-1:0] r_cnt;
    logic             r_last;
    state_t           r_state;

    logic             w_accept;
    logic             w_drain;
    logic             w_close;
    logic [CNT_W-1:0] w_idx;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign out_valid = (r_state == S_HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_drain   = out_valid && out_ready;
    // An accept while holding always coincides with a drain, so the new word starts a fresh block at slot 0
    assign w_idx     = out_valid ? '0 : r_cnt;
    assign w_cnt_nxt = w_idx + CNT_W'(1);
    assign w_close   = w_accept && (in_last || w_cnt_nxt == CNT_W'(DEPTH));
    assign out_count = r_cnt;
    assign out_last  = r_last;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_slot
            localparam int HI = FIRST_AT_MSB ? (DEPTH - i) * WIDTH - 1 : (i + 1) * WIDTH - 1;
            assign out_data[HI -: WIDTH] = r_slot[i];
            // Per-slot write by index; a drain zeroes slots not being refilled this cycle
            always_ff @(posedge clk) begin
                if (rst)
                    r_slot[i] <= '0;
                else if (w_accept && w_idx == CNT_W'(i))
                    r_slot[i] <= in_data;
                else if (w_drain)
                    r_slot[i] <= '0;
            end
        end
    endgenerate

    // FILL/HOLD state, fill count and last flag; accept takes priority over a plain drain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
            r_cnt   <= '0;
            r_last  <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= w_cnt_nxt;
            r_state <= w_close ? S_HOLD : S_FILL;
            r_last  <= w_close && in_last;
        end else if (w_drain) begin
            r_state <= S_FILL;
            r_cnt   <= '0;
            r_last  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sipo_stream_buffer.sv
// tb_sipo_stream_buffer: randomized and directed checks of three packer configurations against a block-level model
module tb_sipo_stream_buffer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       v [3];
    logic       l [3];
    logic       r [3];
    logic       ir [3];
    logic       ov [3];
    logic       ol [3];
    logic [7:0] d [3];
    logic [31:0] od0, od1;
    logic [7:0]  od2;
    logic [2:0]  oc0, oc1;
    logic [0:0]  oc2;

    sipo_stream_buffer #(.WIDTH(8), .DEPTH(4), .FIRST_AT_MSB(1'b1)) u0 (
        .clk(clk), .rst(rst), .in_valid(v[0]), .in_ready(ir[0]), .in_data(d[0]), .in_last(l[0]),
        .out_valid(ov[0]), .out_ready(r[0]), .out_data(od0), .out_count(oc0), .out_last(ol[0]));
    sipo_stream_buffer #(.WIDTH(8), .DEPTH(4), .FIRST_AT_MSB(1'b0)) u1 (
        .clk(clk), .rst(rst), .in_valid(v[1]), .in_ready(ir[1]), .in_data(d[1]), .in_last(l[1]),
        .out_valid(ov[1]), .out_ready(r[1]), .out_data(od1), .out_count(oc1), .out_last(ol[1]));
    sipo_stream_buffer #(.WIDTH(8), .DEPTH(1), .FIRST_AT_MSB(1'b1)) u2 (
        .clk(clk), .rst(rst), .in_valid(v[2]), .in_ready(ir[2]), .in_data(d[2]), .in_last(l[2]),
        .out_valid(ov[2]), .out_ready(r[2]), .out_data(od2), .out_count(oc2), .out_last(ol[2]));

    int n_vec = 0;
    int n_err = 0;

    int   dep [3] = '{4, 4, 1};
    bit   msb [3] = '{1'b1, 1'b0, 1'b1};
    bit   m_hold [3];
    logic [7:0] m_w [3][4];
    int   m_n [3];
    logic [31:0] m_data [3];
    int   m_cnt [3];
    bit   m_last [3];

    task automatic check(input int u, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL u%0d %s observed=%h expected=%h", u, tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int u);
        logic [31:0] x;
        x = '0;
        for (int k = 0; k < m_n[u]; k++)
            x |= 32'(m_w[u][k]) << (8 * (msb[u] ? dep[u] - 1 - k : k));
        return x;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 3; u++) begin
            m_hold[u] = 1'b0; m_n[u] = 0; m_data[u] = '0; m_cnt[u] = 0; m_last[u] = 1'b0;
        end
    endtask

    task automatic model_step(input int u, input bit vi, input logic [7:0] di, input bit li, input bit ri);
        bit acc, drn;
        acc = vi && (!m_hold[u] || ri);
        drn = m_hold[u] && ri;
        if (drn) begin
            m_hold[u] = 1'b0; m_n[u] = 0; m_data[u] = '0; m_cnt[u] = 0; m_last[u] = 1'b0;
        end
        if (acc) begin
            m_w[u][m_n[u]] = di;
            m_n[u]++;
            if (li || m_n[u] == dep[u]) begin
                m_hold[u] = 1'b1; m_data[u] = pack(u); m_cnt[u] = m_n[u]; m_last[u] = li;
            end
        end
    endtask

    task automatic cycle(input int u, input bit vi, input logic [7:0] di, input bit li, input bit ri);
        logic [31:0] od;
        logic [2:0]  oc;
        v[u] = vi; d[u] = di; l[u] = li; r[u] = ri;
        #1;
        od = u == 0 ? od0 : u == 1 ? od1 : {24'b0, od2};
        oc = u == 0 ? oc0 : u == 1 ? oc1 : {2'b0, oc2};
        check(u, "in_ready", 32'(ir[u]), 32'(!m_hold[u] || ri));
        check(u, "out_valid", 32'(ov[u]), 32'(m_hold[u]));
        if (m_hold[u]) begin
            check(u, "out_data", od, m_data[u]);
            check(u, "out_count", 32'(oc), 32'(m_cnt[u]));
            check(u, "out_last", 32'(ol[u]), 32'(m_last[u]));
        end
        model_step(u, vi, di, li, ri);
        @(posedge clk);
        #1;
        v[u] = 1'b0; r[u] = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset(input bit vi);
        rst = 1'b1;
        for (int u = 0; u < 3; u++) begin
            v[u] = vi; d[u] = 8'hEE; l[u] = 1'b1; r[u] = 1'b1;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int u = 0; u < 3; u++) begin
            v[u] = 1'b0; l[u] = 1'b0; r[u] = 1'b0;
        end
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 3; u++) begin
            v[u] = 1'b0; d[u] = '0; l[u] = 1'b0; r[u] = 1'b0;
        end
        model_reset();
        @(negedge clk);
        do_reset(1'b1);
        check(0, "rst out_valid", 32'(ov[0]), 32'd0);
        check(0, "rst out_count", 32'(oc0), 32'd0);
        check(0, "rst out_last", 32'(ol[0]), 32'd0);
        check(0, "rst out_data", od0, 32'd0);
        check(1, "rst out_data", od1, 32'd0);
        check(2, "rst out_valid", 32'(ov[2]), 32'd0);

        // full block under back-pressure
        cycle(0, 1, 8'h11, 0, 0);
        cycle(0, 1, 8'h22, 0, 0);
        cycle(0, 1, 8'h33, 0, 0);
        cycle(0, 1, 8'h44, 0, 0);
        check(0, "t1 data", od0, 32'h11223344);
        check(0, "t1 count", 32'(oc0), 32'd4);
        check(0, "t1 last", 32'(ol[0]), 32'd0);
        check(0, "t1 in_ready", 32'(ir[0]), 32'd0);

        // held block stays stable while input keeps offering words
        for (int k = 0; k < 10; k++) cycle(0, 1, 8'($urandom), 1, 0);
        check(0, "t3 data held", od0, 32'h11223344);
        cycle(0, 0, 8'h00, 0, 1);
        cycle(0, 0, 8'h00, 0, 1);
        check(0, "t3 single drain", 32'(ov[0]), 32'd0);

        // partial flush
        cycle(0, 1, 8'hAA, 0, 0);
        cycle(0, 1, 8'hBB, 1, 0);
        check(0, "t2 data", od0, 32'hAABB0000);
        check(0, "t2 count", 32'(oc0), 32'd2);
        check(0, "t2 last", 32'(ol[0]), 32'd1);
        cycle(0, 0, 8'h00, 0, 1);

        // streaming with the consumer always ready
        for (int k = 1; k <= 12; k++) cycle(0, 1, 8'(k), 0, 1);
        check(0, "t4 third block", od0, 32'h090A0B0C);
        cycle(0, 0, 8'h00, 0, 1);

        // reset mid-fill discards partial words
        cycle(0, 1, 8'h11, 0, 0);
        cycle(0, 1, 8'h22, 0, 0);
        do_reset(1'b0);
        cycle(0, 1, 8'h55, 0, 0);
        cycle(0, 1, 8'h66, 0, 0);
        cycle(0, 1, 8'h77, 0, 0);
        cycle(0, 1, 8'h88, 0, 0);
        check(0, "t5 data", od0, 32'h55667788);
        check(0, "t5 count", 32'(oc0), 32'd4);
        cycle(0, 0, 8'h00, 0, 1);

        // LSB-first packing and DEPTH=1 pass-through
        cycle(1, 1, 8'h11, 0, 0);
        cycle(1, 1, 8'h22, 0, 0);
        cycle(1, 1, 8'h33, 0, 0);
        cycle(1, 1, 8'h44, 0, 0);
        check(1, "t6 lsb data", od1, 32'h44332211);
        cycle(1, 0, 8'h00, 0, 1);
        for (int k = 0; k < 6; k++) cycle(2, 1, 8'(8'hC0 + k), 0, 1);
        check(2, "t6 d1 data", {24'b0, od2}, 32'h000000C5);
        check(2, "t6 d1 count", 32'(oc2), 32'd1);
        cycle(2, 0, 8'h00, 0, 1);

        // randomized traffic on every configuration
        for (int u = 0; u < 3; u++)
            for (int k = 0; k < 400; k++)
                cycle(u, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0,
                      $urandom_range(0, 2) != 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
